mips_control_register_scoreboard: RTL

- Parametrised, pipelined successor to the per-instruction register control generator.
- Carries each issued instruction's resolved register control (read addresses, write address, write enable, load flag) down a STAGES-deep shift pipeline.
- From that in-flight state it produces per-read-port forwarding selects, a load-use stall, and the write-back commit.
- Sits between decode/issue and the execute/memory/write-back datapath.

---
 rtl/mips_control_register_scoreboard_pkg.sv | 20 ++
 rtl/mips_control_register_scoreboard_match.sv | 43 ++++
 rtl/mips_control_register_scoreboard.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mips_control_register_scoreboard_pkg.sv
// Shared constants and helpers for the register control scoreboard.
// Entry field widths, forward-select encoding and select width derivation.
package mips_control_register_scoreboard_pkg;

    localparam int FWD_REGFILE = 0;
    localparam int R0_ADDR     = 0;

    // entry = {valid, rs1, rs2, we, waddr, load}: three flags plus three addresses
    localparam int ENTRY_FLAGS = 3;
    localparam int ENTRY_ADDRS = 3;

    function automatic int entry_width(input int addr_w);
        return ENTRY_FLAGS + ENTRY_ADDRS * addr_w;
    endfunction

    function automatic int sel_width(input int stages);
        return (stages < 2) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/mips_control_register_scoreboard_match.sv
// Finds the youngest in-flight writer of an address within a stage window.
// Reports hit, the stage index of that writer, and whether it is a load.
module mips_control_register_scoreboard_match
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int STAGES    = 3,
    parameter int ADDR_W    = 5,
    parameter int SEL_W     = sel_width(STAGES),
    parameter int LO        = 0,
    parameter int HI        = STAGES - 1,
    parameter int LOAD_ONLY = 0
) (
    input  logic [ADDR_W-1:0]             addr,
    input  logic [STAGES-1:0]             valid,
    input  logic [STAGES-1:0]             we,
    input  logic [STAGES-1:0]             load,
    input  logic [STAGES-1:0][ADDR_W-1:0] waddr,
    output logic                          hit,
    output logic [SEL_W-1:0]              idx,
    output logic                          is_load
);

    logic unused_window;

    // stages outside [LO, HI] are legitimately ignored
    assign unused_window = ^{valid, we, load, waddr};

    always_comb begin
        hit     = 1'b0;
        idx     = SEL_W'(FWD_REGFILE);
        is_load = 1'b0;
        // scan old to young so the youngest match is written last
        for (int s = HI; s >= LO; s--) begin
            if (addr != ADDR_W'(R0_ADDR) && valid[s] && we[s] &&
                waddr[s] == addr && (LOAD_ONLY == 0 || load[s])) begin
                hit     = 1'b1;
                idx     = SEL_W'(s);
                is_load = load[s];
            end
        end
    end

endmodule

// File: rtl/mips_control_register_scoreboard.sv
// In-flight register control pipeline producing forwarding selects,
// load-use stall and write-back commit for a MIPS-style datapath.
module mips_control_register_scoreboard
    import mips_control_register_scoreboard_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int ADDR_W     = 5,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = sel_width(STAGES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              advance,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              issue_we,
    input  logic [ADDR_W-1:0] issue_waddr,
    input  logic              issue_load,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [SEL_W-1:0]  fwd_sel2,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr
);

    localparam int LAST = STAGES - 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic              load;
    } entry_t;

    entry_t                        stage_q [STAGES];
    entry_t                        issue_entry;
    logic                          take;
    logic                          hazard;
    logic [STAGES-1:0]             st_valid;
    logic [STAGES-1:0]             st_we;
    logic [STAGES-1:0]             st_load;
    logic [STAGES-1:0][ADDR_W-1:0] st_waddr;
    logic                          hit1;
    logic                          hit2;
    logic                          ld1;
    logic                          ld2;
    logic [SEL_W-1:0]              idx1;
    logic [SEL_W-1:0]              idx2;
    logic                          unused_bits;

    // a write to R0 is dropped at capture so it can never match or commit
    always_comb begin
        issue_entry.valid = 1'b1;
        issue_entry.rs1   = issue_rs1;
        issue_entry.rs2   = issue_rs2;
        issue_entry.we    = issue_we && (issue_waddr != ADDR_W'(R0_ADDR));
        issue_entry.waddr = issue_waddr;
        issue_entry.load  = issue_load;
    end

    assign take = issue_valid && !stall && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++)
                stage_q[s] <= '0;
        end else if (advance) begin
            for (int s = LAST; s >= 2; s--)
                stage_q[s] <= stage_q[s-1];
            stage_q[1] <= flush ? '0 : stage_q[0];
            stage_q[0] <= take ? issue_entry : '0;
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            st_valid[s] = stage_q[s].valid;
            st_we[s]    = stage_q[s].we;
            st_load[s]  = stage_q[s].load;
            st_waddr[s] = stage_q[s].waddr;
        end
    end

    mips_control_register_scoreboard_match #(
        .STAGES(STAGES), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
        .LO(1), .HI(LAST), .LOAD_ONLY(0)
    ) u_fwd1 (
        .addr(stage_q[0].rs1), .valid(st_valid), .we(st_we),
        .load(st_load), .waddr(st_waddr),
        .hit(hit1), .idx(idx1), .is_load(ld1)
    );

    mips_control_register_scoreboard_match #(
        .STAGES(STAGES), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
        .LO(1), .HI(LAST), .LOAD_ONLY(0)
    ) u_fwd2 (
        .addr(stage_q[0].rs2), .valid(st_valid), .we(st_we),
        .load(st_load), .waddr(st_waddr),
        .hit(hit2), .idx(idx2), .is_load(ld2)
    );

    assign fwd_sel1 = (stage_q[0].valid && hit1) ? idx1 : SEL_W'(FWD_REGFILE);
    assign fwd_sel2 = (stage_q[0].valid && hit2) ? idx2 : SEL_W'(FWD_REGFILE);

    generate
        if (LOAD_READY >= 2) begin : g_haz
            logic             h1;
            logic             h2;
            logic             l1;
            logic             l2;
            logic [SEL_W-1:0] i1;
            logic [SEL_W-1:0] i2;
            logic             unused_haz;

            mips_control_register_scoreboard_match #(
                .STAGES(STAGES), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
                .LO(0), .HI(LOAD_READY - 2), .LOAD_ONLY(1)
            ) u_haz1 (
                .addr(issue_rs1), .valid(st_valid), .we(st_we),
                .load(st_load), .waddr(st_waddr),
                .hit(h1), .idx(i1), .is_load(l1)
            );

            mips_control_register_scoreboard_match #(
                .STAGES(STAGES), .ADDR_W(ADDR_W), .SEL_W(SEL_W),
                .LO(0), .HI(LOAD_READY - 2), .LOAD_ONLY(1)
            ) u_haz2 (
                .addr(issue_rs2), .valid(st_valid), .we(st_we),
                .load(st_load), .waddr(st_waddr),
                .hit(h2), .idx(i2), .is_load(l2)
            );

            assign hazard     = h1 | h2;
            assign unused_haz = ^{i1, i2, l1, l2};
        end else begin : g_no_haz
            assign hazard = 1'b0;
        end
    endgenerate

    assign stall = issue_valid && !flush && hazard;

    assign wb_valid = stage_q[LAST].valid && stage_q[LAST].we;
    assign wb_addr  = wb_valid ? stage_q[LAST].waddr : ADDR_W'(R0_ADDR);

    // read addresses past stage 0 travel along but are not consulted
    always_comb begin
        unused_bits = ld1 ^ ld2;
        for (int s = 1; s < STAGES; s++)
            unused_bits = unused_bits ^ (^{stage_q[s].rs1, stage_q[s].rs2});
    end

endmodule
